// File: rtl/dsp_issue_ctrl_pkg.sv
// Shared definitions for the DSP issue controller: mode encodings,
// per-mode issue lengths, FSM state encoding and response FIFO sizing.
package dsp_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_17X17   = 2'd0,
        MODE_17X33   = 2'd1,
        MODE_33X33   = 2'd2,
        MODE_ILLEGAL = 2'd3
    } dsp_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } issue_state_e;

    // Number of cycles the operands are presented to the DSP for each mode.
    localparam int CYC_17X17   = 1;
    localparam int CYC_17X33   = 2;
    localparam int CYC_33X33   = 4;
    localparam int CYC_ILLEGAL = 1;

    localparam int CNT_W      = 2;
    localparam int RSP_DEPTH  = 2;
    localparam int RSP_CNT_W  = $clog2(RSP_DEPTH + 1);

    // Value of cnt on the final issue cycle of an op in the given mode.
    function automatic logic [CNT_W-1:0] op_last_cnt(input logic [1:0] mode);
        case (mode)
            MODE_17X17:  return CNT_W'(CYC_17X17 - 1);
            MODE_17X33:  return CNT_W'(CYC_17X33 - 1);
            MODE_33X33:  return CNT_W'(CYC_33X33 - 1);
            default:     return CNT_W'(CYC_ILLEGAL - 1);
        endcase
    endfunction

endpackage

// File: rtl/dsp_issue_ctrl_rsp_fifo.sv
// Small synchronous FIFO holding {err, data} responses; push and pop may
// coincide, including when full.
module dsp_rsp_fifo
    import dsp_issue_ctrl_pkg::*;
#(
    parameter int DW    = 67,
    parameter int DEPTH = RSP_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic [DW-1:0]                pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dsp_issue_ctrl.sv
// Issue controller for a multi-cycle DSP multiplier: registers a request,
// holds it on the DSP bus for the mode's cycle count, then queues the result.
module dsp_issue_ctrl
    import dsp_issue_ctrl_pkg::*;
#(
    parameter int WIDTH      = 33,
    parameter int SHIFT_BITS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WIDTH-1:0]       req_a,
    input  logic [WIDTH-1:0]       req_b,
    input  logic [2*WIDTH-1:0]     req_c,
    input  logic [1:0]             req_mode,
    input  logic                   req_mac,
    input  logic [SHIFT_BITS-1:0]  req_shift_amt,
    input  logic                   req_shift_dir,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*WIDTH-1:0]     rsp_data,
    output logic                   rsp_err,
    output logic                   dsp_start,
    output logic                   dsp_mac,
    output logic                   dsp_shift_dir,
    output logic [WIDTH-1:0]       dsp_aa,
    output logic [WIDTH-1:0]       dsp_bb,
    output logic [2*WIDTH-1:0]     dsp_cc,
    output logic [1:0]             dsp_mode,
    output logic [SHIFT_BITS-1:0]  dsp_shift_amount,
    input  logic [2*WIDTH-1:0]     dsp_out,
    output logic                   busy,
    output issue_state_e           dbg_state
);

    localparam int RW = 2 * WIDTH;
    localparam int EW = RW + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready, payload is stable while
    // valid is high and not yet accepted.

    issue_state_e          state;
    logic [CNT_W-1:0]      cnt;
    logic                  in_issue;
    logic                  op_last;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  room;
    logic                  fifo_empty;
    logic [RSP_CNT_W-1:0]  fifo_count;
    logic [RSP_CNT_W:0]    need;
    logic [EW-1:0]         push_entry;
    logic [EW-1:0]         head_entry;

    assign dbg_state = state;
    assign in_issue  = (state == ST_ISSUE);
    assign op_last   = in_issue && (cnt == op_last_cnt(dsp_mode));

    // The op on the DSP already owns a FIFO slot, so a new op is only taken
    // when queued results plus the in-flight op leave space after any pop.
    assign need      = {1'b0, fifo_count}
                     + {{RSP_CNT_W{1'b0}}, in_issue}
                     - {{RSP_CNT_W{1'b0}}, pop};
    assign room      = (need < (RSP_CNT_W + 1)'(RSP_DEPTH));
    assign req_ready = rst_n && (!in_issue || op_last) && room;
    assign accept    = req_valid && req_ready;

    assign push       = op_last;
    assign pop        = rsp_valid && rsp_ready;
    assign push_entry = (dsp_mode == MODE_ILLEGAL) ? {1'b1, {RW{1'b0}}}
                                                   : {1'b0, dsp_out};

    assign rsp_valid = !fifo_empty;
    assign rsp_err   = head_entry[RW];
    assign rsp_data  = head_entry[RW-1:0];
    assign busy      = in_issue || !fifo_empty;

    // The DSP bus registers double as the op registers: loaded on accept,
    // held through the op, parked at idle values between ops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            dsp_start        <= 1'b0;
            dsp_mac          <= 1'b0;
            dsp_shift_dir    <= 1'b0;
            dsp_aa           <= '0;
            dsp_bb           <= '0;
            dsp_cc           <= '0;
            dsp_mode         <= MODE_ILLEGAL;
            dsp_shift_amount <= '0;
        end else if (accept) begin
            state            <= ST_ISSUE;
            cnt              <= '0;
            dsp_start        <= 1'b1;
            dsp_mac          <= req_mac;
            dsp_shift_dir    <= req_shift_dir;
            dsp_aa           <= req_a;
            dsp_bb           <= req_b;
            dsp_cc           <= req_c;
            dsp_mode         <= req_mode;
            dsp_shift_amount <= req_shift_amt;
        end else if (op_last) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            dsp_start        <= 1'b0;
            dsp_mac          <= 1'b0;
            dsp_shift_dir    <= 1'b0;
            dsp_aa           <= '0;
            dsp_bb           <= '0;
            dsp_cc           <= '0;
            dsp_mode         <= MODE_ILLEGAL;
            dsp_shift_amount <= '0;
        end else if (in_issue) begin
            cnt       <= cnt + 1'b1;
            dsp_start <= 1'b0;
        end
    end

    dsp_rsp_fifo #(
        .DW    (EW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule
